motor_ramp_limiter: RTL and testbench
=====================================

// Module: motor_ramp_limiter
// PURPOSE
//  Upstream stage of each H-bridge motor_controller: turns signed speed commands from the CPU register
//  bank into slew-limited {dir, on, duty_cycle}. Magnitude moves toward target by bounded steps per tick.
//  Direction reversals ramp to zero and coast for a dwell before restarting, so the bridge never sees
//  a hard reversal. Immediate stop via enable; optional command watchdog.
// PARAMETERS
//  DC_W       `DUTY_CYCLE_SIZE (10)  duty magnitude width; matches motor_controller duty_cycle
//  RAMP_DIV   50000                  clk cycles per ramp tick (1 ms @ 50 MHz), >=2
//  STEP       8                      max magnitude change per tick, 1..2^DC_W-1
//  ZERO_HOLD  20                     ticks with on=0 between direction change, >=1
//  WDT_CYCLES 25000000               watchdog timeout in clk cycles (MOTOR_WATCHDOG_EN only)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  enable       in   1       0 = immediate stop, no ramp
//  cmd_valid    in   1       single-cycle strobe; latch cmd_speed
//  cmd_speed    in   DC_W+1  signed two's-complement speed; sign -> dir (>=0 -> dir=1)
//  dir          out  1       to motor_controller dir
//  on           out  1       to motor_controller on
//  duty_cycle   out  DC_W    to motor_controller duty_cycle (current magnitude)
//  at_target    out  1       mag==tgt_mag and (tgt_mag==0 or dir==tgt_dir)
//  wdt_expired  out  1       sticky watchdog flag (tied 0 without MOTOR_WATCHDOG_EN)
// BEHAVIOUR
//  - Reset: state IDLE, mag=0, tgt_mag=0, tgt_dir=1, dir=1, on=0, duty_cycle=0, at_target=1,
//    wdt_expired=0, prescaler=0, dwell count=0. Asserting mid-operation aborts at once; no ramp.
//  - Command: on cmd_valid edge, tgt_dir=~cmd_speed[DC_W]; tgt_mag=|cmd_speed|, saturated to
//    2^DC_W-1 (-2^DC_W -> 2^DC_W-1). Always accepted, no backpressure; new target mid-ramp
//    redirects the ramp from the current mag.
//  - Tick: prescaler counts 0..RAMP_DIV-1; tick is one cycle at wrap. State only moves on tick,
//    except enable/reset.
//  - IDLE (mag=0, on=0): on tick with tgt_mag!=0: dir<=tgt_dir, mag<=min(STEP,tgt_mag), ->RAMP.
//  - RAMP: on tick, if tgt_mag==0 or tgt_dir!=dir: mag<=sat0(mag-STEP); on reaching 0 ->DWELL if
//    reversing, else ->IDLE. Otherwise mag steps toward tgt_mag by <=STEP, never overshoots; holds
//    in RAMP once equal.
//  - DWELL: on=0; count ZERO_HOLD ticks; then tgt_mag==0 ->IDLE, else dir<=tgt_dir, mag<=
//    min(STEP,tgt_mag), ->RAMP. A target flip back to the old dir mid-dwell still completes dwell.
//  - Outputs registered: on=(state==RAMP)&&(mag!=0); duty_cycle=mag; updated on the tick edge.
//    Latency: cmd_valid -> first output change at the first tick after the latch edge.
//  - enable=0: next edge mag=0, on=0, ->IDLE, dwell count cleared; target retained. Simultaneous
//    cmd_valid still latches. After enable returns, ramp starts from 0 on the next tick.
//  - Arithmetic: mag+STEP computed DC_W+1 bits wide, clamped to tgt_mag; subtraction floors at 0.
// CONFIGURATION
//  MOTOR_WATCHDOG_EN defined: counter cleared by cmd_valid; at WDT_CYCLES, tgt_mag<=0 (normal
//  ramp-down) and wdt_expired<=1, sticky until next cmd_valid (which wins if same cycle).
//  Undefined: no counter, wdt_expired constant 0, WDT_CYCLES unused.
// STRUCTURE
//  - defines.v: DUTY_CYCLE_SIZE, state encodings (`RL_IDLE, `RL_RAMP, `RL_DWELL), default
//    RAMP_DIV/STEP/ZERO_HOLD.
//  - Sub-module ramp_tick_gen (clk, reset, enable -> tick): prescaler; counter held at 0 while
//    enable=0.
//  - Top: target latch, FSM, magnitude datapath, optional watchdog.
// TESTING (DC_W=10, RAMP_DIV=4, STEP=8, ZERO_HOLD=2, WDT_CYCLES=100)
//  1 reset mid-ramp at mag=40 -> same cycle: on=0, duty=0, dir=1, at_target=1; stays until cmd.
//  2 cmd +100 -> duty 8,16,..,96,100 every 4 clks, on=1, dir=1; at_target after 13th tick.
//  3 at +100, cmd -40 -> duty 92..4,0; on=0 for 2 ticks; then dir=0, duty 8..40, at_target=1.
//  4 enable=0 at duty=48 -> next edge duty=0, on=0; enable=1 -> restart 8,16,.. to tgt.
//  5 cmd -1024 -> tgt 1023, dir=0; ramp ends at 1023 (no wrap); cmd 0 -> ramp to 0, IDLE, on=0.
//  6 [MOTOR_WATCHDOG_EN] cmd +64, no further cmd -> at clk 100 wdt_expired=1, ramp to 0;
//    cmd +16 -> wdt_expired=0, ramp to 16. Without macro: wdt_expired stays 0, duty holds 64.

Source files
------------

// File: rtl/motor_ramp_limiter_pkg.sv
// Shared constants and state encoding for the motor ramp limiter.
// Default ramp timing matches a 50 MHz system clock.
package motor_ramp_limiter_pkg;

  localparam int DUTY_CYCLE_SIZE = 10;
  localparam int RL_RAMP_DIV     = 50000;
  localparam int RL_STEP         = 8;
  localparam int RL_ZERO_HOLD    = 20;
  localparam int RL_WDT_CYCLES   = 25000000;

  typedef enum logic [1:0] {
    RL_IDLE  = 2'd0,
    RL_RAMP  = 2'd1,
    RL_DWELL = 2'd2
  } rl_state_e;

endpackage

// File: rtl/motor_ramp_limiter_tick_gen.sv
// Ramp prescaler: one-cycle tick every RAMP_DIV clocks.
// Held at zero while the limiter is disabled.
module motor_ramp_limiter_tick_gen #(
  parameter int RAMP_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(RAMP_DIV);
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == LAST);
  assign tick = enable && wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor_ramp_limiter.sv
// Slew-limited speed command stage ahead of the H-bridge motor_controller.
// Define MOTOR_WATCHDOG_EN to add the command watchdog.
module motor_ramp_limiter
  import motor_ramp_limiter_pkg::*;
#(
  parameter int DC_W       = DUTY_CYCLE_SIZE,
  parameter int RAMP_DIV   = RL_RAMP_DIV,
  parameter int STEP       = RL_STEP,
  parameter int ZERO_HOLD  = RL_ZERO_HOLD,
  parameter int WDT_CYCLES = RL_WDT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            cmd_valid,
  input  logic [DC_W:0]   cmd_speed,
  output logic            dir,
  output logic            on,
  output logic [DC_W-1:0] duty_cycle,
  output logic            at_target,
  output logic            wdt_expired
);

  localparam logic [DC_W-1:0] STEP_V = DC_W'(STEP);
  localparam logic [DC_W-1:0] MAX_V  = '1;
  localparam logic [DC_W:0]   ONE_X  = (DC_W + 1)'(1);
  localparam int HW = $clog2(ZERO_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ZERO_HOLD - 1);

  rl_state_e       state, state_n;
  logic [DC_W-1:0] mag, mag_n;
  logic            dir_n, on_n;
  logic [HW-1:0]   hold, hold_n;
  logic [DC_W-1:0] tgt_mag;
  logic            tgt_dir;
  logic            tick;
  logic            wdt_fire;

  logic [DC_W:0]   cmd_neg, cmd_abs;
  logic [DC_W-1:0] cmd_mag;
  logic [DC_W:0]   sum;
  logic [DC_W-1:0] up, dn_raw, dn_tgt, first;
  logic            leaving;

  motor_ramp_limiter_tick_gen #(
    .RAMP_DIV (RAMP_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // -2^DC_W has no positive twin; it saturates to full scale
  assign cmd_neg = ~cmd_speed + ONE_X;
  assign cmd_abs = cmd_speed[DC_W] ? cmd_neg : cmd_speed;
  assign cmd_mag = cmd_abs[DC_W] ? MAX_V : cmd_abs[DC_W-1:0];

  assign sum     = {1'b0, mag} + {1'b0, STEP_V};
  assign up      = (sum > {1'b0, tgt_mag}) ? tgt_mag : sum[DC_W-1:0];
  assign dn_raw  = (mag > STEP_V) ? (mag - STEP_V) : '0;
  assign dn_tgt  = (dn_raw < tgt_mag) ? tgt_mag : dn_raw;
  assign first   = (tgt_mag < STEP_V) ? tgt_mag : STEP_V;
  assign leaving = (tgt_mag == '0) || (tgt_dir != dir);

  always_comb begin
    state_n = state;
    mag_n   = mag;
    dir_n   = dir;
    on_n    = on;
    hold_n  = hold;
    if (!enable) begin
      state_n = RL_IDLE;
      mag_n   = '0;
      on_n    = 1'b0;
      hold_n  = '0;
    end else if (tick) begin
      unique case (state)
        RL_IDLE: begin
          if (tgt_mag != '0) begin
            dir_n   = tgt_dir;
            mag_n   = first;
            on_n    = 1'b1;
            state_n = RL_RAMP;
          end
        end
        RL_RAMP: begin
          if (leaving) begin
            mag_n = dn_raw;
            if (dn_raw == '0) begin
              on_n    = 1'b0;
              state_n = (tgt_mag != '0) ? RL_DWELL : RL_IDLE;
            end
          end else if (mag < tgt_mag) begin
            mag_n = up;
          end else if (mag > tgt_mag) begin
            mag_n = dn_tgt;
          end
        end
        RL_DWELL: begin
          if (hold == HOLD_LAST) begin
            hold_n = '0;
            if (tgt_mag == '0) begin
              state_n = RL_IDLE;
            end else begin
              dir_n   = tgt_dir;
              mag_n   = first;
              on_n    = 1'b1;
              state_n = RL_RAMP;
            end
          end else begin
            hold_n = hold + 1'b1;
          end
        end
        default: state_n = RL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RL_IDLE;
      mag   <= '0;
      dir   <= 1'b1;
      on    <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      mag   <= mag_n;
      dir   <= dir_n;
      on    <= on_n;
      hold  <= hold_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_mag <= '0;
      tgt_dir <= 1'b1;
    end else if (cmd_valid) begin
      tgt_mag <= cmd_mag;
      tgt_dir <= ~cmd_speed[DC_W];
    end else if (wdt_fire) begin
      tgt_mag <= '0;
    end
  end

`ifdef MOTOR_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt;

  assign wdt_fire = !wdt_expired && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
    end else if (cmd_valid) begin
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
    end else if (wdt_fire) begin
      wdt_expired <= 1'b1;
    end else if (!wdt_expired) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_wdt;

  assign unused_wdt  = ^WDT_CYCLES;
  assign wdt_fire    = 1'b0;
  assign wdt_expired = 1'b0;
`endif

  assign duty_cycle = mag;
  assign at_target  = (mag == tgt_mag) &&
                      ((tgt_mag == '0) || (dir == tgt_dir));

endmodule

// File: tb/tb_motor_ramp_limiter.sv
// Scoreboard bench for motor_ramp_limiter.
// Build with MOTOR_WATCHDOG_EN to exercise the watchdog path.
module tb_motor_ramp_limiter;

  localparam int DC_W      = 10;
  localparam int RAMP_DIV  = 4;
  localparam int STEP      = 8;
  localparam int ZERO_HOLD = 2;
  localparam int WDT       = 100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [DC_W:0]   cmd_speed = '0;
  logic            dir, on, at_target, wdt_expired;
  logic [DC_W-1:0] duty_cycle;

  typedef struct {
    logic            dir;
    logic            on;
    logic [DC_W-1:0] duty;
    int              gap;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              passed = 0;
  int              cyc = 0;
  logic [DC_W+1:0] prev;

  motor_ramp_limiter #(
    .DC_W       (DC_W),
    .RAMP_DIV   (RAMP_DIV),
    .STEP       (STEP),
    .ZERO_HOLD  (ZERO_HOLD),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_speed   (cmd_speed),
    .dir         (dir),
    .on          (on),
    .duty_cycle  (duty_cycle),
    .at_target   (at_target),
    .wdt_expired (wdt_expired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // gap 0 means first change after a command: any tick phase is legal
  task automatic push(input logic d, input logic o, input int v, input int g);
    exp_t e;
    e.dir = d;
    e.on = o;
    e.duty = DC_W'(v);
    e.gap = g;
    sb.push_back(e);
  endtask

  task automatic wait_change(input int budget, output logic [DC_W+1:0] snap,
                             output int gap, output bit tmo);
    gap = 0;
    tmo = 1'b1;
    snap = prev;
    while (gap < budget) begin
      @(negedge clk);
      cyc++;
      gap++;
      snap = {dir, on, duty_cycle};
      if (snap !== prev) begin
        tmo = 1'b0;
        prev = snap;
        break;
      end
    end
  endtask

  task automatic send(input int s);
    cmd_speed = (DC_W + 1)'(s);
    cmd_valid = 1'b1;
    @(negedge clk);
    cyc++;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    tick_n(3);
    checks++;
    if ({dir, on, duty_cycle} !== {1'b1, 1'b0, 10'd0}) begin
      $display("FAIL rst_out: got %0d/%0d/%0d want 1/0/0", dir, on, duty_cycle);
    end else passed++;
    checks++;
    if ({at_target, wdt_expired} !== 2'b10) begin
      $display("FAIL rst_flags: got %b want 10", {at_target, wdt_expired});
    end else passed++;
    reset = 1'b0;
    prev = {1'b1, 1'b0, 10'd0};
    wait_change(12, snap, gap, tmo);
    checks++;
    if (!tmo) begin
      $display("FAIL rst_idle: got change %h want none", snap);
    end else passed++;
  endtask

  task automatic test_reset_mid_ramp;
    exp_t e;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    send(-100);
    for (int k = 1; k <= 5; k++) push(1'b0, 1'b1, 8 * k, k == 1 ? 0 : 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL mid_seq: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dir, on, duty_cycle, at_target} !== {1'b1, 1'b0, 10'd0, 1'b1}) begin
      $display("FAIL mid_rst: got %0d/%0d/%0d/%0d want 1/0/0/1",
               dir, on, duty_cycle, at_target);
    end else passed++;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    prev = {1'b1, 1'b0, 10'd0};
    wait_change(20, snap, gap, tmo);
    checks++;
    if (!tmo) begin
      $display("FAIL mid_hold: got change %h want none", snap);
    end else passed++;
  endtask

  task automatic test_ramp_up;
    exp_t e;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    int i;
    send(100);
    for (int k = 1; k <= 12; k++) push(1'b1, 1'b1, 8 * k, k == 1 ? 0 : 4);
    push(1'b1, 1'b1, 100, 4);
    i = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      i++;
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL up_seq: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
      if (i == 12) begin
        checks++;
        if (at_target !== 1'b0) begin
          $display("FAIL up_early_tgt: got %b want 0", at_target);
        end else passed++;
      end
    end
    checks++;
    if (at_target !== 1'b1) begin
      $display("FAIL up_at_target: got %b want 1", at_target);
    end else passed++;
  endtask

  task automatic test_reversal;
    exp_t e;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    send(-40);
    for (int k = 1; k <= 12; k++) push(1'b1, 1'b1, 100 - 8 * k, k == 1 ? 0 : 4);
    push(1'b1, 1'b0, 0, 4);
    push(1'b0, 1'b1, 8, 4 * ZERO_HOLD);
    for (int k = 2; k <= 5; k++) push(1'b0, 1'b1, 8 * k, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL rev_seq: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
    checks++;
    if (at_target !== 1'b1) begin
      $display("FAIL rev_at_target: got %b want 1", at_target);
    end else passed++;
  endtask

  task automatic test_enable;
    exp_t e;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    send(-200);
    push(1'b0, 1'b1, 48, 0);
    e = sb.pop_front();
    wait_change(40, snap, gap, tmo);
    checks++;
    if (tmo || snap !== {e.dir, e.on, e.duty}) begin
      $display("FAIL en_pre: got %h tmo %0d want %h", snap, tmo, {e.dir, e.on, e.duty});
    end else passed++;
    enable = 1'b0;
    wait_change(3, snap, gap, tmo);
    checks++;
    if (tmo || gap != 1 || snap !== {1'b0, 1'b0, 10'd0}) begin
      $display("FAIL en_stop: got %h gap %0d want 000 gap 1", snap, gap);
    end else passed++;
    send(-240);
    tick_n(4);
    checks++;
    if ({on, duty_cycle} !== 11'd0) begin
      $display("FAIL en_held: got %0d/%0d want 0/0", on, duty_cycle);
    end else passed++;
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) push(1'b0, 1'b1, 8 * k, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} || gap != e.gap) begin
        $display("FAIL en_seq: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
  endtask

  task automatic test_saturation;
    exp_t e;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    send(-1024);
    for (int k = 31; k <= 127; k++) push(1'b0, 1'b1, 8 * k, k == 31 ? 0 : 4);
    push(1'b0, 1'b1, 1023, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL sat_up: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
    checks++;
    if (at_target !== 1'b1) begin
      $display("FAIL sat_at_target: got %b want 1", at_target);
    end else passed++;
    send(0);
    for (int k = 1; k <= 127; k++) push(1'b0, 1'b1, 1023 - 8 * k, k == 1 ? 0 : 4);
    push(1'b0, 1'b0, 0, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL sat_down: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
    wait_change(20, snap, gap, tmo);
    checks++;
    if (!tmo || at_target !== 1'b1) begin
      $display("FAIL sat_idle: got %h tgt %b want idle tgt 1", snap, at_target);
    end else passed++;
  endtask

  task automatic test_watchdog;
    exp_t e;
    logic [DC_W+1:0] snap;
    int gap;
    bit tmo;
    int c0;
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    prev = {1'b1, 1'b0, 10'd0};
    send(64);
    c0 = cyc;
    for (int k = 1; k <= 8; k++) push(1'b1, 1'b1, 8 * k, k == 1 ? 0 : 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL wdt_up: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
`ifdef MOTOR_WATCHDOG_EN
    checks++;
    if (wdt_expired !== 1'b0) begin
      $display("FAIL wdt_early: got %b want 0", wdt_expired);
    end else passed++;
    while (wdt_expired !== 1'b1 && cyc - c0 < 300) tick_n(1);
    checks++;
    if (cyc - c0 != WDT) begin
      $display("FAIL wdt_time: got %0d want %0d", cyc - c0, WDT);
    end else passed++;
    for (int k = 1; k <= 7; k++) push(1'b1, 1'b1, 64 - 8 * k, k == 1 ? 0 : 4);
    push(1'b1, 1'b0, 0, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL wdt_down: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
    send(16);
    checks++;
    if (wdt_expired !== 1'b0) begin
      $display("FAIL wdt_clear: got %b want 0", wdt_expired);
    end else passed++;
    push(1'b1, 1'b1, 8, 0);
    push(1'b1, 1'b1, 16, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_change(40, snap, gap, tmo);
      checks++;
      if (tmo || snap !== {e.dir, e.on, e.duty} ||
          !(e.gap == 0 ? (gap >= 1 && gap <= RAMP_DIV) : gap == e.gap)) begin
        $display("FAIL wdt_rearm: got %h gap %0d tmo %0d want %h gap %0d",
                 snap, gap, tmo, {e.dir, e.on, e.duty}, e.gap);
      end else passed++;
    end
`else
    tick_n(150 - (cyc - c0));
    checks++;
    if (wdt_expired !== 1'b0) begin
      $display("FAIL wdt_off_flag: got %b want 0", wdt_expired);
    end else passed++;
    checks++;
    if ({on, duty_cycle} !== {1'b1, 10'd64}) begin
      $display("FAIL wdt_off_hold: got %0d/%0d want 1/64", on, duty_cycle);
    end else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_ramp();
    test_ramp_up();
    test_reversal();
`ifndef MOTOR_WATCHDOG_EN
    test_enable();
    test_saturation();
`endif
    test_watchdog();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
